// File: rtl/cgra_axi_pkg.sv
// Shared AXI4-Lite definitions for the CGRA scratchpad responders.
package cgra_axi_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

endpackage : cgra_axi_pkg

// File: rtl/cgra_axil_sram.sv
// Single-port synchronous word SRAM: per-byte write enable, one-cycle read, no reset.
// The read register only updates on a read, so it holds its word across later writes.
module cgra_axil_sram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_W     = $clog2(DEPTH),
    parameter int unsigned STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [STRB_W-1:0]     wr_be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane writes and registered read on the shared port
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wr_be[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule : cgra_axil_sram

// File: rtl/cgra_axil_sram_slave.sv
// AXI4-Lite responder in front of a single-port word SRAM scratchpad.
// One-entry AW/W/AR hold slots feed an alternating read/write arbiter; B and R
// each carry at most one outstanding response.
module cgra_axil_sram_slave
    import cgra_axi_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int unsigned           STRB_W     = DATA_WIDTH / 8;
    localparam int unsigned           IDX_W      = $clog2(DEPTH);
    localparam int unsigned           BYTE_SHIFT = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] WINDOW     = ADDR_WIDTH'(DEPTH * STRB_W);

    logic                  aw_full_q, w_full_q, ar_full_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic                  awready_q, wready_q, arready_q;
    logic                  bvalid_q, rvalid_q, r_ok_q;
    axi_resp_t             bresp_q, rresp_q;
    logic                  last_grant_wr_q;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_elig, rd_elig, grant_wr, grant_rd;
    logic                  aw_full_d, w_full_d, ar_full_d;
    logic                  aw_borrow, ar_borrow, aw_ok, ar_ok;
    logic [ADDR_WIDTH-1:0] aw_off, ar_off;
    logic [IDX_W-1:0]      sram_addr;
    logic [STRB_W-1:0]     sram_be;
    logic                  sram_rd;
    logic [DATA_WIDTH-1:0] sram_rdata;

    // Handshakes, eligibility, alternating arbitration and slot occupancy
    always_comb begin
        aw_hs     = s_axi_awvalid && awready_q;
        w_hs      = s_axi_wvalid  && wready_q;
        ar_hs     = s_axi_arvalid && arready_q;
        wr_elig   = aw_full_q && w_full_q && !bvalid_q;
        rd_elig   = ar_full_q && !rvalid_q;
        grant_wr  = wr_elig && (!rd_elig || !last_grant_wr_q);
        grant_rd  = rd_elig && (!wr_elig ||  last_grant_wr_q);
        aw_full_d = aw_hs || (aw_full_q && !grant_wr);
        w_full_d  = w_hs  || (w_full_q  && !grant_wr);
        ar_full_d = ar_hs || (ar_full_q && !grant_rd);
    end

    // Window decode; the borrow bit flags addresses below BASE_ADDR
    always_comb begin
        {aw_borrow, aw_off} = {1'b0, aw_addr_q} - {1'b0, BASE_ADDR};
        {ar_borrow, ar_off} = {1'b0, ar_addr_q} - {1'b0, BASE_ADDR};
        aw_ok = !aw_borrow && (aw_off < WINDOW);
        ar_ok = !ar_borrow && (ar_off < WINDOW);
    end

    // Shared SRAM port: grants are exclusive, out-of-range accesses touch nothing
    always_comb begin
        sram_addr = grant_wr ? aw_off[BYTE_SHIFT +: IDX_W] : ar_off[BYTE_SHIFT +: IDX_W];
        sram_be   = (grant_wr && aw_ok) ? w_strb_q : '0;
        sram_rd   = grant_rd && ar_ok;
    end

    cgra_axil_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sram (
        .clk   (clk),
        .rd_en (sram_rd),
        .wr_be (sram_be),
        .addr  (sram_addr),
        .wdata (w_data_q),
        .rdata (sram_rdata)
    );

    // Hold slots and their registered ready flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            ar_full_q <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            ar_full_q <= ar_full_d;
            awready_q <= !aw_full_d;
            wready_q  <= !w_full_d;
            arready_q <= !ar_full_d;
            if (aw_hs) aw_addr_q <= s_axi_awaddr;
            if (ar_hs) ar_addr_q <= s_axi_araddr;
            if (w_hs) begin
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
        end
    end

    // Arbiter history plus B and R response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_wr_q <= 1'b1;
            bvalid_q        <= 1'b0;
            bresp_q         <= AXI_RESP_OKAY;
            rvalid_q        <= 1'b0;
            rresp_q         <= AXI_RESP_OKAY;
            r_ok_q          <= 1'b0;
        end else begin
            if (grant_wr || grant_rd) last_grant_wr_q <= grant_wr;

            if (grant_wr) begin
                bvalid_q <= 1'b1;
                bresp_q  <= aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            if (grant_rd) begin
                rvalid_q <= 1'b1;
                r_ok_q   <= ar_ok;
                rresp_q  <= ar_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
                r_ok_q   <= 1'b0;
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    // SRAM read register holds the word until the next read; gate it for errors and idle
    assign s_axi_rdata   = r_ok_q ? sram_rdata : '0;

endmodule : cgra_axil_sram_slave

// File: tb/tb_cgra_axil_sram_slave.sv
// Directed bench for cgra_axil_sram_slave: latency, strobes, backpressure,
// arbitration order, window decode and mid-transaction reset.
module tb_cgra_axil_sram_slave;
    import cgra_axi_pkg::*;

    localparam int unsigned LIMIT = 50;

    logic        clk;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    cgra_axil_sram_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (1024),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        bit aw_f, w_f, aw_d, w_d;
        n = 0; aw_d = 0; w_d = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_d && w_d) && n < LIMIT) begin
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            tick(); n++;
            if (aw_f) begin awvalid = 1'b0; aw_d = 1; end
            if (w_f)  begin wvalid  = 1'b0; w_d  = 1; end
        end
        while (!bvalid && n < LIMIT) begin tick(); n++; end
        check("wr_timeout", 64'(n >= LIMIT), 64'd0);
        resp = bresp;
        tick();
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        bit ar_f, ar_d;
        n = 0; ar_d = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!ar_d && n < LIMIT) begin
            ar_f = arvalid && arready;
            tick(); n++;
            if (ar_f) begin arvalid = 1'b0; ar_d = 1; end
        end
        while (!rvalid && n < LIMIT) begin tick(); n++; end
        check("rd_timeout", 64'(n >= LIMIT), 64'd0);
        d = rdata;
        resp = rresp;
        tick();
        rready = 1'b0; arvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        rst_n = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready",  64'(wready),  64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_bvalid",  64'(bvalid),  64'd0);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_bresp",   64'(bresp),   64'd0);
        check("rst_rresp",   64'(rresp),   64'd0);
        check("rst_rdata",   64'(rdata),   64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_awready_low", 64'(awready), 64'd0);
        tick();
        check("rel_awready", 64'(awready), 64'd1);
        check("rel_wready",  64'(wready),  64'd1);
        check("rel_arready", 64'(arready), 64'd1);

        // 1: write latency and readback
        awaddr = 32'h10; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t1_bvalid_n1",  64'(bvalid),  64'd0);
        check("t1_awready_n1", 64'(awready), 64'd0);
        tick();
        check("t1_bvalid_n2", 64'(bvalid), 64'd1);
        check("t1_bresp",     64'(bresp),  64'(AXI_RESP_OKAY));
        tick();
        check("t1_bvalid_hold", 64'(bvalid), 64'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("t1_bvalid_drop", 64'(bvalid), 64'd0);
        axi_read(32'h10, d, r);
        check("t1_rdata", 64'(d), 64'hDEAD_BEEF);
        check("t1_rresp", 64'(r), 64'(AXI_RESP_OKAY));

        // 2: byte strobes merge into an existing word
        axi_write(32'h14, 32'h1122_3344, 4'hF, r);
        check("t2_bresp0", 64'(r), 64'(AXI_RESP_OKAY));
        axi_write(32'h14, 32'hAABB_CCDD, 4'b0101, r);
        axi_read(32'h14, d, r);
        check("t2_rdata", 64'(d), 64'h11BB_33DD);

        // 3: W before AW, B backpressure fills both slots
        bready = 1'b0;
        awaddr = 32'h20; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("t3_wready_full", 64'(wready), 64'd0);
        tick();
        tick();
        check("t3_bvalid_noaw", 64'(bvalid), 64'd0);
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("t3_bvalid_aw1", 64'(bvalid), 64'd0);
        tick();
        check("t3_bvalid_aw2", 64'(bvalid), 64'd1);
        check("t3_awready_free", 64'(awready), 64'd1);
        check("t3_wready_free",  64'(wready),  64'd1);
        awaddr = 32'h24; wdata = 32'h0BAD_F00D; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_awready_stall", 64'(awready), 64'd0);
            check("t3_wready_stall",  64'(wready),  64'd0);
            check("t3_bvalid_stall",  64'(bvalid),  64'd1);
            check("t3_bresp_stable",  64'(bresp),   64'(AXI_RESP_OKAY));
        end
        bready = 1'b1;
        tick();
        check("t3_bvalid_gap", 64'(bvalid), 64'd0);
        tick();
        check("t3_bvalid_2nd",  64'(bvalid),  64'd1);
        check("t3_awready_2nd", 64'(awready), 64'd1);
        tick();
        bready = 1'b0;
        axi_read(32'h20, d, r);
        check("t3_rdata_20", 64'(d), 64'hCAFE_F00D);
        axi_read(32'h24, d, r);
        check("t3_rdata_24", 64'(d), 64'h0BAD_F00D);

        // 4: simultaneous eligibility from reset alternates R,W,R,W,...
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bready = 1'b1; rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            awaddr = 32'h40 + 32'(4 * i); wdata = 32'hA0A0_0000 + 32'(i); wstrb = 4'hF;
            araddr = 32'h10;
            awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
            tick();
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
            tick();
            check("t4_first_r_rvalid", 64'(rvalid), 64'd1);
            check("t4_first_r_bvalid", 64'(bvalid), 64'd0);
            check("t4_rdata",          64'(rdata),  64'hDEAD_BEEF);
            tick();
            check("t4_then_w_bvalid", 64'(bvalid), 64'd1);
            check("t4_then_w_rvalid", 64'(rvalid), 64'd0);
            tick();
            check("t4_b_done", 64'(bvalid), 64'd0);
        end
        bready = 1'b0; rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            axi_read(32'h40 + 32'(4 * i), d, r);
            check("t4_wdata_back", 64'(d), 64'hA0A0_0000 + 64'(i));
        end

        // 5: window boundaries and out-of-range accesses
        axi_write(32'h0, 32'h5A5A_0000, 4'hF, r);
        axi_write(32'hFFC, 32'h0000_A5A5, 4'hF, r);
        check("t5_last_bresp", 64'(r), 64'(AXI_RESP_OKAY));
        axi_read(32'h1000, d, r);
        check("t5_oor_rdata", 64'(d), 64'd0);
        check("t5_oor_rresp", 64'(r), 64'(AXI_RESP_SLVERR));
        axi_write(32'h1000, 32'hFFFF_FFFF, 4'hF, r);
        check("t5_oor_bresp", 64'(r), 64'(AXI_RESP_SLVERR));
        axi_read(32'h0, d, r);
        check("t5_word0", 64'(d), 64'h5A5A_0000);
        axi_read(32'hFFC, d, r);
        check("t5_wordlast", 64'(d), 64'h0000_A5A5);
        check("t5_wordlast_resp", 64'(r), 64'(AXI_RESP_OKAY));

        // 6: reset while both responses are pending
        bready = 1'b0; rready = 1'b0;
        awaddr = 32'h30; wdata = 32'h600D_D00D; wstrb = 4'hF; araddr = 32'h10;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        tick();
        check("t6_bvalid_pre", 64'(bvalid), 64'd1);
        check("t6_rvalid_pre", 64'(rvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_bvalid_rst",  64'(bvalid),  64'd0);
        check("t6_rvalid_rst",  64'(rvalid),  64'd0);
        check("t6_awready_rst", 64'(awready), 64'd0);
        check("t6_wready_rst",  64'(wready),  64'd0);
        check("t6_arready_rst", 64'(arready), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_awready_rel", 64'(awready), 64'd1);
        axi_read(32'h10, d, r);
        check("t6_keep_10", 64'(d), 64'hDEAD_BEEF);
        axi_read(32'h14, d, r);
        check("t6_keep_14", 64'(d), 64'h11BB_33DD);
        axi_read(32'h30, d, r);
        check("t6_keep_30", 64'(d), 64'h600D_D00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cgra_axil_sram_slave
